// File: rtl/exe_unit_seq.sv
// Multi-cycle execution unit sitting behind the APB slave.
// Runs one command at a time through a start/busy/done handshake.
// SHIFT, ROTATE and POPCOUNT advance one bit per clock, so no barrel logic is needed.
// Result and status are registered. A saturating counter tracks errored commands.
module exe_unit_seq #(
    parameter int unsigned M     = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [M-1:0]     i_argA,
    input  logic [M-1:0]     i_argB,
    output logic             o_busy,
    output logic             o_done,
    output logic [M-1:0]     o_result,
    output logic [3:0]       o_stat,
    output logic [CNT_W-1:0] o_err_cnt
);

    // Step counter must hold N=M, used by POPCOUNT.
    localparam int unsigned CW = $clog2(M) + 1;

    localparam logic [M-1:0] M_VAL    = M[M-1:0];
    localparam logic [M-1:0] ONE      = {{(M-1){1'b0}}, 1'b1};
    localparam logic [M-1:0] MSB_ONLY = {1'b1, {(M-1){1'b0}}};

    typedef enum logic [2:0] {
        OpSet     = 3'b000,
        OpShift   = 3'b001,
        OpCompare = 3'b010,
        OpChanger = 3'b011,
        OpRotate  = 3'b100,
        OpPopcnt  = 3'b101,
        OpIll6    = 3'b110,
        OpIll7    = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StWrite
    } state_e;

    state_e        state_q;
    op_e           op_q;
    logic [M-1:0]  a_q;
    logic [M-1:0]  b_q;
    logic [M-1:0]  acc_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] pop_q;
    logic          ovf_q;

    logic [CW-1:0] start_steps;
    logic [M-1:0]  fin_res;
    logic          fin_ovf;
    logic          fin_err;

    // Number of iteration steps for the command being offered on the inputs.
    always_comb begin
        start_steps = '0;
        case (op_e'(i_op))
            // Out-of-range shift is an error and completes without iterating.
            OpShift:  if (i_argB < M_VAL) start_steps = CW'(i_argB);
            OpRotate: start_steps = CW'(i_argB % M_VAL);
            OpPopcnt: start_steps = CW'(M);
            default:  start_steps = '0;
        endcase
    end

    // Final result, overflow and error for the latched command.
    always_comb begin
        fin_res = '0;
        fin_ovf = 1'b0;
        fin_err = 1'b0;
        case (op_q)
            OpSet: begin
                fin_err = (b_q >= M_VAL);
                fin_res = a_q | (ONE << b_q);
            end
            OpShift: begin
                fin_err = (b_q >= M_VAL);
                fin_res = acc_q;
                fin_ovf = ovf_q;
            end
            OpCompare: begin
                if ($signed(a_q) > $signed(b_q)) begin
                    fin_res = ONE;
                end else if (a_q == b_q) begin
                    fin_res = '0;
                end else begin
                    fin_res = '1;
                end
            end
            OpChanger: begin
                fin_res = -a_q;
                fin_ovf = (a_q == MSB_ONLY);
            end
            OpRotate: fin_res = acc_q;
            OpPopcnt: fin_res = M'(pop_q);
            default:  fin_err = 1'b1;
        endcase
    end

    // Control FSM with working registers and registered outputs.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= StIdle;
            op_q      <= OpSet;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            pop_q     <= '0;
            ovf_q     <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_result  <= '0;
            o_stat    <= '0;
            o_err_cnt <= '0;
        end else begin
            o_done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_start) begin
                        op_q    <= op_e'(i_op);
                        a_q     <= i_argA;
                        b_q     <= i_argB;
                        acc_q   <= i_argA;
                        cnt_q   <= start_steps;
                        pop_q   <= '0;
                        ovf_q   <= 1'b0;
                        o_busy  <= 1'b1;
                        state_q <= (start_steps == '0) ? StWrite : StRun;
                    end
                end
                StRun: begin
                    case (op_q)
                        OpShift: begin
                            ovf_q <= ovf_q | acc_q[M-1];
                            acc_q <= acc_q << 1;
                        end
                        OpRotate: acc_q <= {acc_q[M-2:0], acc_q[M-1]};
                        OpPopcnt: begin
                            pop_q <= pop_q + CW'(acc_q[0]);
                            acc_q <= acc_q >> 1;
                        end
                        default: ;
                    endcase
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= StWrite;
                end
                StWrite: begin
                    if (fin_err) begin
                        o_result <= '0;
                        o_stat   <= 4'b1000;
                        if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + 1'b1;
                    end else begin
                        o_result <= fin_res;
                        o_stat   <= {1'b0, fin_ovf, fin_res[M-1], fin_res == '0};
                    end
                    o_done  <= 1'b1;
                    o_busy  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_unit_seq.sv
// Directed bench for exe_unit_seq at M=8, CNT_W=8.
module tb_exe_unit_seq;

    localparam int unsigned M     = 8;
    localparam int unsigned CNT_W = 8;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             start  = 1'b0;
    logic [2:0]       op     = 3'b000;
    logic [M-1:0]     arg_a  = '0;
    logic [M-1:0]     arg_b  = '0;
    logic             busy;
    logic             done;
    logic [M-1:0]     result;
    logic [3:0]       stat;
    logic [CNT_W-1:0] err_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exe_unit_seq #(
        .M     (M),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst_n),
        .i_start   (start),
        .i_op      (op),
        .i_argA    (arg_a),
        .i_argB    (arg_b),
        .o_busy    (busy),
        .o_done    (done),
        .o_result  (result),
        .o_stat    (stat),
        .o_err_cnt (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer a command at the falling edge; returns #1 after the accepting edge E0.
    task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        arg_a = a;
        arg_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        arg_a = 8'h5A;
        arg_b = 8'hA5;
    endtask

    // Count edges after E0 until done, bounded; lat0 = edges already elapsed.
    task automatic wait_done(input string tag, input int lat0, input int exp_lat,
                             input logic [7:0] exp_res, input logic [3:0] exp_stat);
        int lat;
        lat = lat0;
        while (done !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "/lat"}, lat, exp_lat);
        chk({tag, "/res"}, result, exp_res);
        chk({tag, "/stat"}, stat, exp_stat);
        chk({tag, "/busy"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #12;
        chk("rst/busy", busy, 1'b0);
        chk("rst/done", done, 1'b0);
        chk("rst/res", result, 8'h00);
        chk("rst/stat", stat, 4'h0);
        chk("rst/cnt", err_cnt, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // SET
        issue(3'b000, 8'h07, 8'd3);
        chk("set1/busy", busy, 1'b1);
        wait_done("set1", 0, 1, 8'h0F, 4'b0000);
        issue(3'b000, 8'hB0, 8'd0);
        wait_done("set2", 0, 1, 8'hB1, 4'b0010);

        // SHIFT with ignored start pulse mid-run
        issue(3'b001, 8'hC3, 8'd5);
        chk("shf/busy0", busy, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("shf/busy2", busy, 1'b1);
        @(negedge clk);
        start = 1'b1;
        op    = 3'b000;
        arg_a = 8'h00;
        arg_b = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("shf", 3, 6, 8'h60, 4'b0100);
        @(posedge clk); #1;
        chk("shf/nodone", done, 1'b0);
        chk("shf/noacc", busy, 1'b0);
        chk("shf/hold", result, 8'h60);

        // SHIFT by zero
        issue(3'b001, 8'h5A, 8'd0);
        wait_done("shf0", 0, 1, 8'h5A, 4'b0000);

        // CHANGER
        issue(3'b011, 8'd120, 8'd0);
        wait_done("chg1", 0, 1, 8'h88, 4'b0010);
        issue(3'b011, 8'h80, 8'd0);
        wait_done("chg2", 0, 1, 8'h80, 4'b0110);
        issue(3'b011, 8'h00, 8'd0);
        wait_done("chg3", 0, 1, 8'h00, 4'b0001);

        // COMPARE
        issue(3'b010, 8'd11, 8'd14);
        wait_done("cmp1", 0, 1, 8'hFF, 4'b0010);
        issue(3'b010, 8'd11, 8'd9);
        wait_done("cmp2", 0, 1, 8'h01, 4'b0000);
        issue(3'b010, 8'd10, 8'd10);
        wait_done("cmp3", 0, 1, 8'h00, 4'b0001);
        issue(3'b010, 8'hFE, 8'd1);
        wait_done("cmp4", 0, 1, 8'hFF, 4'b0010);

        // ROTATE then back-to-back POPCOUNT, accepted in the done cycle
        issue(3'b100, 8'h81, 8'd9);
        wait_done("rot", 0, 2, 8'h03, 4'b0000);
        issue(3'b101, 8'hB0, 8'd0);
        chk("b2b/busy", busy, 1'b1);
        chk("b2b/done", done, 1'b0);
        wait_done("pop", 0, 9, 8'h03, 4'b0000);
        chk("pop/cnt", err_cnt, 8'd0);

        // Errors
        issue(3'b000, 8'h01, 8'd9);
        wait_done("err1", 0, 1, 8'h00, 4'b1000);
        chk("err1/cnt", err_cnt, 8'd1);
        issue(3'b110, 8'h01, 8'd1);
        wait_done("err2", 0, 1, 8'h00, 4'b1000);
        chk("err2/cnt", err_cnt, 8'd2);
        issue(3'b001, 8'h01, 8'd8);
        wait_done("err3", 0, 1, 8'h00, 4'b1000);
        chk("err3/cnt", err_cnt, 8'd3);

        // Saturation of the error counter
        for (int i = 0; i < 252; i++) begin
            issue(3'b111, 8'h00, 8'h00);
            wait_done("errs", 0, 1, 8'h00, 4'b1000);
        end
        chk("sat/cnt255", err_cnt, 8'hFF);
        issue(3'b111, 8'h00, 8'h00);
        wait_done("sat", 0, 1, 8'h00, 4'b1000);
        chk("sat/hold", err_cnt, 8'hFF);

        // Reset during SHIFT B=7 at E3
        issue(3'b001, 8'hFF, 8'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort/busy", busy, 1'b0);
        chk("abort/done", done, 1'b0);
        chk("abort/res", result, 8'h00);
        chk("abort/stat", stat, 4'h0);
        chk("abort/cnt", err_cnt, 8'h00);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort/nodone", done, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            chk("post/nodone", done, 1'b0);
        end

        // Unit still works after abort
        issue(3'b000, 8'h00, 8'd0);
        wait_done("post", 0, 1, 8'h01, 4'b0000);
        chk("post/cnt", err_cnt, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
